dmem_atomic_responder: RTL
==========================

Name: dmem_atomic_responder

Overview:
- Memory-side responder for the datapath data port. Services pipeline load/store requests (d_ren/d_wen/d_atomic) with a one-cycle dhit pulse and load data.
- Owns the LL/SC link register and resolves SC success/fail locally.
- Sits between the datapath data port and the RAM arbiter; drives ramREN/ramWEN and waits on ramstate.

Parameters:
- WORD_W, 32, data/address width in bits.
- LINK_LSB, 2, lowest address bit used in link-address compares (word granularity).

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- dmemREN  in  1  load request (LW/LL); held by pipeline until dhit
- dmemWEN  in  1  store request (SW/SC); held by pipeline until dhit
- datomic  in  1  qualifies request as LL (with REN) or SC (with WEN)
- dmemaddr  in  WORD_W  request byte address
- dmemstore  in  WORD_W  store data
- dhit  out  1  one-cycle completion pulse
- dmemload  out  WORD_W  load data; SC result (1 = success, 0 = fail)
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- snoop_valid  in  1  another master wrote snoop_addr this cycle
- snoop_addr  in  WORD_W  address written by another master

Behaviour:
- Reset is the only asynchronous event; everything else is registered on posedge CLK.
- nRST low, including mid-transaction: state=IDLE, dhit=0, dmemload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, link_valid=0, link_addr=0. The RAM strobes drop immediately.
- FSM state IDLE:
  - Samples a request when dmemREN|dmemWEN.
  - If both REN and WEN are set, REN wins.
  - Latches addr, store data and kind (LD, LL, ST, SC).
  - SC with link miss goes directly to DONE with result 0 and no RAM access.
  - All other requests go to ACCESS.
- FSM state ACCESS:
  - Drives ramREN (LD/LL) or ramWEN (ST/SC-pass), with ramaddr and ramstore from the latched values.
  - Stays while ramstate is FREE, BUSY or ERROR (retry).
  - On ramstate==ACCESS: latches ramload (reads) or 1 (SC-pass) into dmemload, then goes to DONE.
- FSM state DONE: dhit=1 for exactly this cycle, then IDLE. dmemload holds until the next completion.
- Latency:
  - Request first seen in cycle N gives ramREN/ramWEN in N+1.
  - If ramstate==ACCESS in cycle M, dhit is in M+1.
  - SC-fail: dhit in N+1.
- No new request is accepted in DONE. The request still held during the DONE cycle is not re-issued, because the pipeline drops it after dhit.
- Link register:
  - LL completion sets link_valid=1 and link_addr=addr.
  - Link hit = link_valid and addr[WORD_W-1:LINK_LSB]==link_addr[WORD_W-1:LINK_LSB].
  - SC (pass or fail) clears link_valid when it completes.
  - A plain ST to a link-hit address clears link_valid when the write completes.
  - Link hit for SC is evaluated in IDLE at sample time.
- Simultaneous LL completion and link clear in the same cycle: set wins, because the LL is newer.

Optional Feature:
- Macro: LINK_SNOOP_EN.
- Defined: snoop_valid with snoop_addr[WORD_W-1:LINK_LSB]==link_addr[WORD_W-1:LINK_LSB] clears link_valid next edge. A snoop in the same cycle as an SC sample in IDLE forces SC fail.
- Not defined: snoop_valid and snoop_addr are ignored. Only local SC/ST clear the link.

Decomposition:
- diaosi_types_pkg gains:
  - enum respstate_t {RS_IDLE, RS_ACCESS, RS_DONE}
  - enum memop_t {OP_LD, OP_LL, OP_ST, OP_SC}
  - constant SC_PASS=32'd1, SC_FAIL=32'd0
- ramstate_t and word_t come from cpu_types_pkg.
- One sub-module, llsc_link_reg: holds link_valid and link_addr. Its ports are set, clear, snoop_valid and snoop_addr, and it outputs a hit compare against a query address.

Test Plan:
- Reset mid-ACCESS: assert REN at 0x100, drop nRST while ramREN=1 -> ramREN=0 immediately; after release, no dhit until a new request.
- LW 0x40, ramstate BUSY 3 cycles then ACCESS with ramload=0xDEADBEEF -> exactly one dhit cycle, dmemload=0xDEADBEEF, ramREN high 4 cycles.
- LL 0x80 then SC 0x80 data 0x5 -> ramWEN with ramstore=0x5; dmemload=1, dhit once; a second SC to 0x80 -> dmemload=0, no ramWEN, dhit one cycle after sample.
- LL 0x80, SW 0x82 (same word), SC 0x80 -> SC fails (dmemload=0), no RAM write.
- LL 0x80, SC 0x84 -> fail, and link is cleared: a following SC 0x80 also fails.
- LINK_SNOOP_EN defined: LL 0x80, snoop_valid with snoop_addr=0x80, then SC 0x80 -> fail. Same sequence with the macro undefined -> pass, dmemload=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word and the RAM arbiter handshake state.
package cpu_types_pkg;

   localparam int CPU_WORD_W = 32;

   typedef logic [CPU_WORD_W-1:0] word_t;

   // State reported by the RAM arbiter for the current strobe.
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Types for the data-memory responder: FSM states, request kinds, SC results.
package diaosi_types_pkg;

   typedef enum logic [1:0] {
      RS_IDLE,
      RS_ACCESS,
      RS_DONE
   } respstate_t;

   typedef enum logic [1:0] {
      OP_LD,
      OP_LL,
      OP_ST,
      OP_SC
   } memop_t;

   localparam logic [31:0] SC_PASS = 32'd1;
   localparam logic [31:0] SC_FAIL = 32'd0;

   // Loads and load-linked drive the RAM read strobe; everything else writes.
   function automatic logic op_is_read(input memop_t op);
      return (op == OP_LD) || (op == OP_LL);
   endfunction

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: one linked address plus a valid flag.
// Set has priority over clear (a completing LL is always newer than any clear).
// Optional macro LINK_SNOOP_EN: a matching remote write (snoop) kills the link
// on the next edge and masks the hit in the same cycle.
module llsc_link_reg #(
   parameter int WORD_W   = 32,
   parameter int LINK_LSB = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              set,
   input  logic              clear,
   input  logic [WORD_W-1:0] set_addr,
   input  logic              snoop_valid,
   input  logic [WORD_W-1:0] snoop_addr,
   input  logic [WORD_W-1:0] query_addr,
   output logic              hit
);

   logic              link_valid_reg;
   logic [WORD_W-1:0] link_addr_reg;
   logic              snoop_kill;

`ifdef LINK_SNOOP_EN
   assign snoop_kill = snoop_valid && link_valid_reg &&
                       (snoop_addr[WORD_W-1:LINK_LSB] == link_addr_reg[WORD_W-1:LINK_LSB]);
`else
   logic unused_snoop;
   assign snoop_kill   = 1'b0;
   assign unused_snoop = ^{snoop_valid, snoop_addr};
`endif

   // Byte-offset bits never take part in the word-granular compare.
   generate
      if (LINK_LSB > 0) begin : g_low_bits
         logic unused_low_bits;
         assign unused_low_bits = ^{link_addr_reg[LINK_LSB-1:0],
                                    query_addr[LINK_LSB-1:0],
                                    snoop_addr[LINK_LSB-1:0]};
      end
   endgenerate

   assign hit = link_valid_reg && !snoop_kill &&
                (query_addr[WORD_W-1:LINK_LSB] == link_addr_reg[WORD_W-1:LINK_LSB]);

   // Link state: LL sets, SC/ST/snoop clear, set wins on collision.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         link_valid_reg <= 1'b0;
         link_addr_reg  <= '0;
      end else if (set) begin
         link_valid_reg <= 1'b1;
         link_addr_reg  <= set_addr;
      end else if (clear || snoop_kill) begin
         link_valid_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/dmem_atomic_responder.sv
// Memory-side responder for the datapath data port. Accepts one load/store
// (including LL/SC) at a time, forwards it to the RAM arbiter, and answers the
// pipeline with a single-cycle dhit. SC success is decided locally from the
// link register; a failing SC completes without touching RAM.
// Optional macro LINK_SNOOP_EN: remote writes seen on snoop_* break the link.
module dmem_atomic_responder
   import cpu_types_pkg::*;
   import diaosi_types_pkg::*;
#(
   parameter int WORD_W   = 32,
   parameter int LINK_LSB = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic              datomic,
   input  logic [WORD_W-1:0] dmemaddr,
   input  logic [WORD_W-1:0] dmemstore,
   output logic              dhit,
   output logic [WORD_W-1:0] dmemload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   input  logic              snoop_valid,
   input  logic [WORD_W-1:0] snoop_addr
);

   respstate_t        state_reg, state_next;
   memop_t            op_reg, op_next;
   logic [WORD_W-1:0] addr_reg, addr_next;
   logic [WORD_W-1:0] store_reg, store_next;
   logic [WORD_W-1:0] load_reg, load_next;

   ramstate_t         ram_st;
   logic              link_hit;
   logic              link_set;
   logic              link_clear;
   logic [WORD_W-1:0] query_addr;

   assign ram_st = ramstate_t'(ramstate);

   // SC hit is judged on the incoming address while idle; store-clear on the latched one.
   assign query_addr = (state_reg == RS_IDLE) ? dmemaddr : addr_reg;
   assign link_set   = (state_reg == RS_DONE) && (op_reg == OP_LL);
   assign link_clear = (state_reg == RS_DONE) &&
                       ((op_reg == OP_SC) || ((op_reg == OP_ST) && link_hit));

   llsc_link_reg #(
      .WORD_W   (WORD_W),
      .LINK_LSB (LINK_LSB)
   ) u_link (
      .CLK         (CLK),
      .nRST        (nRST),
      .set         (link_set),
      .clear       (link_clear),
      .set_addr    (addr_reg),
      .snoop_valid (snoop_valid),
      .snoop_addr  (snoop_addr),
      .query_addr  (query_addr),
      .hit         (link_hit)
   );

   // State and request registers; reset drops the RAM strobes immediately.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg <= RS_IDLE;
         op_reg    <= OP_LD;
         addr_reg  <= '0;
         store_reg <= '0;
         load_reg  <= '0;
      end else begin
         state_reg <= state_next;
         op_reg    <= op_next;
         addr_reg  <= addr_next;
         store_reg <= store_next;
         load_reg  <= load_next;
      end
   end

   // Next-state, request capture, result selection and port decode.
   always_comb begin
      state_next = state_reg;
      op_next    = op_reg;
      addr_next  = addr_reg;
      store_next = store_reg;
      load_next  = load_reg;
      dhit       = 1'b0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = addr_reg;
      ramstore   = store_reg;
      dmemload   = load_reg;

      case (state_reg)
         RS_IDLE: begin
            if (dmemREN || dmemWEN) begin
               addr_next  = dmemaddr;
               store_next = dmemstore;
               if (dmemREN) begin
                  op_next = datomic ? OP_LL : OP_LD;
               end else begin
                  op_next = datomic ? OP_SC : OP_ST;
               end
               if (!dmemREN && datomic && !link_hit) begin
                  load_next  = WORD_W'(SC_FAIL);
                  state_next = RS_DONE;
               end else begin
                  state_next = RS_ACCESS;
               end
            end
         end
         RS_ACCESS: begin
            ramREN = op_is_read(op_reg);
            ramWEN = !op_is_read(op_reg);
            if (ram_st == ACCESS) begin
               if (op_is_read(op_reg)) begin
                  load_next = ramload;
               end else if (op_reg == OP_SC) begin
                  load_next = WORD_W'(SC_PASS);
               end
               state_next = RS_DONE;
            end
         end
         RS_DONE: begin
            dhit       = 1'b1;
            state_next = RS_IDLE;
         end
         default: begin
            state_next = RS_IDLE;
         end
      endcase
   end

endmodule
